cbm2_busarb: RTL
================

Name: cbm2_busarb

Overview:
- Parametrised multi-master arbiter and sequencer for the shared system RAM port.
- Successor to the fixed CPU/video cycle split: NM masters (CPU, video, IPC co-processor, future DMA) each issue request/acknowledge transactions.
- Block grants one master at a time, drives systemAddr/systemWe/cs_ram for a configurable access window, and returns read data to a per-master holding register.
- Sits between the master-side bus decoders and the RAM controller.

Parameters:
NM, 3, number of masters (2..8)
AW, 25, system address width
DW, 8, data width
RAM_WAIT, 1, extra cycles the address is held before ramData is sampled (0..7)
VID_IDX, 0, index of the video master
VID_PRIO, 1, 1 = video master has fixed top priority; 0 = video joins round-robin

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous active-high reset
m_req  in  NM  per-master request, held high until its m_ack
m_we  in  NM  per-master write enable
m_addr  in  NM*AW  per-master address, master i at bits [i*AW +: AW]
m_wdata  in  NM*DW  per-master write data
m_ack  out  NM  one-cycle completion pulse per master
m_rdata  out  NM*DW  per-master last read data, held
systemAddr  out  AW  RAM address
systemWe  out  1  RAM write enable
systemDo  out  DW  RAM write data
cs_ram  out  1  RAM select
ramData  in  DW  RAM read data
busy  out  1  high in ACCESS
grant_id  out  3  index of the current or last granted master

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - All outputs 0: m_ack, m_rdata, systemAddr, systemWe, systemDo, cs_ram, busy, grant_id.
  - Round-robin pointer rr = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any m_req is set, arbitrate and go to ACCESS on the next edge.
  - On that edge, register the winner's addr, we and wdata, and set grant_id.
- Arbitration:
  - If VID_PRIO=1 and m_req[VID_IDX], video wins.
  - Otherwise, pick the first requester scanning from rr+1 upward modulo NM, skipping VID_IDX when VID_PRIO=1.
  - rr is updated to the winner only for round-robin wins.
- ACCESS:
  - Lasts RAM_WAIT+1 cycles, counted by a 3-bit counter.
  - cs_ram=1 and busy=1 throughout. systemAddr and systemDo come from the latched values.
  - systemWe = latched we, for the entire window.
  - On a read, ramData is registered at the edge ending the last ACCESS cycle.
  - Go to DONE.
- DONE:
  - m_ack[grant_id]=1 for exactly this cycle.
  - On a read, m_rdata[grant_id] shows the new data from this cycle onward.
  - cs_ram, systemWe, systemAddr and systemDo return to 0.
  - Arbitrate again with the just-acked master excluded (its req is still high this cycle).
  - If there is a winner, go to ACCESS (back-to-back). Otherwise go to IDLE.
- Latency and throughput:
  - A request seen in IDLE at cycle 0 gets m_ack at cycle RAM_WAIT+2.
  - Sustained throughput is one transfer per RAM_WAIT+2 cycles.
- Data holding:
  - Writes never change m_rdata.
  - Each m_rdata slice holds its value until that master's next completed read.
- Master-side changes during an access:
  - Changes to m_addr, m_we or m_wdata after grant are ignored.
  - A req dropped during ACCESS does not abort: the access completes and ack still pulses.
- Arbitration boundary conditions:
  - Simultaneous requests from all masters: serviced in arbitration order, no master granted twice while another waits (except video with VID_PRIO=1).
  - rr wraps from NM-1 to 0.
- Reset mid-ACCESS:
  - Immediate return to IDLE; cs_ram and systemWe deassert asynchronously.
  - No ack is issued and m_rdata is cleared.
- Parameter checks:
  - NM < 2 or NM > 8 is a synthesis-time error.
  - VID_IDX >= NM is a synthesis-time error.

Test Plan:
- RAM_WAIT=1: master 1 reads 0x0F1234 with ramData=0xA5 at cycle 0 -> cs_ram high cycles 1–2, systemAddr=0x0F1234, m_ack[1] at cycle 3, m_rdata[1]=0xA5 held afterwards.
- Master 2 writes 0x3C to 0x000400 -> systemWe=1 and systemDo=0x3C for 2 cycles; m_rdata[2] unchanged; ack at cycle 3.
- Masters 1 and 2 requesting continuously, VID_PRIO=1, video idle -> grants alternate 1,2,1,2 back-to-back, acks every 3 cycles, no IDLE cycles between.
- Video requests while master 1 waits and master 2 is in ACCESS -> after master 2's DONE, video is granted before master 1.
- Reset asserted in the 2nd ACCESS cycle -> cs_ram=0 and systemWe=0 immediately, no m_ack, FSM in IDLE, next request is serviced normally.
- Master 1 changes m_addr from 0x000010 to 0x000020 during ACCESS, RAM_WAIT=3 -> systemAddr stays 0x000010 for all 4 cycles; ack at cycle 5.

Source files
------------

// File: rtl/cbm2_busarb.sv
// Shared system-RAM arbiter: grants one of NM masters per transfer, drives the RAM
// port for RAM_WAIT+1 cycles, then acks the master and keeps its last read byte.
module cbm2_busarb #(
    parameter int NM       = 3,
    parameter int AW       = 25,
    parameter int DW       = 8,
    parameter int RAM_WAIT = 1,
    parameter int VID_IDX  = 0,
    parameter int VID_PRIO = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [NM-1:0]     m_req,
    input  logic [NM-1:0]     m_we,
    input  logic [NM*AW-1:0]  m_addr,
    input  logic [NM*DW-1:0]  m_wdata,
    output logic [NM-1:0]     m_ack,
    output logic [NM*DW-1:0]  m_rdata,
    output logic [AW-1:0]     systemAddr,
    output logic              systemWe,
    output logic [DW-1:0]     systemDo,
    output logic              cs_ram,
    input  logic [DW-1:0]     ramData,
    output logic              busy,
    output logic [2:0]        grant_id
);

    generate
        if (NM < 2 || NM > 8) begin : g_bad_nm
            $error("cbm2_busarb: NM must be in 2..8");
        end
        if (VID_IDX < 0 || VID_IDX >= NM) begin : g_bad_vid
            $error("cbm2_busarb: VID_IDX must be below NM");
        end
        if (RAM_WAIT < 0 || RAM_WAIT > 7) begin : g_bad_wait
            $error("cbm2_busarb: RAM_WAIT must be in 0..7");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        rr_q, rr_d;
    logic [2:0]        grant_q, grant_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [DW-1:0]     do_q, do_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic [NM-1:0]     ack_q, ack_d;
    logic [NM*DW-1:0]  rdata_q, rdata_d;

    logic [7:0]        req_m;
    logic              arb_found;
    logic              arb_rr;
    logic [2:0]        arb_win;
    logic [3:0]        scan;
    logic [AW-1:0]     sel_addr;
    logic              sel_we;
    logic [DW-1:0]     sel_wdata;

    // In DONE the just-acked master still holds req, so it is masked out for this round.
    always_comb begin
        req_m     = '0;
        arb_found = 1'b0;
        arb_rr    = 1'b0;
        arb_win   = '0;
        scan      = '0;
        for (int i = 0; i < NM; i++) begin
            req_m[i] = m_req[i] && !(state_q == DONE && grant_q == 3'(i));
        end
        if (VID_PRIO != 0 && req_m[VID_IDX]) begin
            arb_found = 1'b1;
            arb_win   = 3'(VID_IDX);
        end else begin
            for (int k = 1; k <= NM; k++) begin
                scan = {1'b0, rr_q} + 4'(k);
                if (scan >= 4'(NM)) scan = scan - 4'(NM);
                if (!arb_found && req_m[scan[2:0]] &&
                    !(VID_PRIO != 0 && scan[2:0] == 3'(VID_IDX))) begin
                    arb_found = 1'b1;
                    arb_rr    = 1'b1;
                    arb_win   = scan[2:0];
                end
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NM; i++) begin
            if (arb_win == 3'(i)) begin
                sel_addr  = m_addr[i*AW +: AW];
                sel_we    = m_we[i];
                sel_wdata = m_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        do_d    = do_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                busy_d  = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                do_d    = '0;
                if (arb_found) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    grant_d = arb_win;
                    addr_d  = sel_addr;
                    we_d    = sel_we;
                    do_d    = sel_wdata;
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                    if (arb_rr) rr_d = arb_win;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'(RAM_WAIT)) begin
                    state_d = DONE;
                    cs_d    = 1'b0;
                    busy_d  = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    do_d    = '0;
                    for (int i = 0; i < NM; i++) begin
                        if (grant_q == 3'(i)) begin
                            ack_d[i] = 1'b1;
                            if (!we_q) rdata_d[i*DW +: DW] = ramData;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            do_q    <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            do_q    <= do_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign m_ack      = ack_q;
    assign m_rdata    = rdata_q;
    assign systemAddr = addr_q;
    assign systemWe   = we_q;
    assign systemDo   = do_q;
    assign cs_ram     = cs_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule
